// File: rtl/module_hazard_sequencer.sv
// ============================================================================
// module_hazard_sequencer : pipeline enable/flush sequencer (optional HAZARD_PERF_CNT_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module module_hazard_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  input  logic       ex_branch_taken_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  output logic       en_pc_o,
  output logic       en_ifid_o,
  output logic       en_idex_o,
  output logic       en_exmem_o,
  output logic       en_memwb_o,
  output logic       flush_ifid_o,
  output logic       flush_idex_o,
  output logic       mem_fault_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;

  logic       mem_stall;
  logic       mem_done;
  logic       load_use;
  logic [4:0] run_en;
  logic       run_flush_ifid;
  logic       run_flush_idex;
  logic [4:0] en;
  logic       flush_ifid;
  logic       flush_idex;

  assign mem_stall = dmem_req_i & ~dmem_ack_i;
  assign mem_done  = dmem_req_i & dmem_ack_i;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_memread_i & (ex_rd_i != 5'd0) &
                    ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                     (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  // Unfrozen pipe behaviour; a taken branch squashes the dependent instruction anyway.
  always_comb begin
    run_en         = 5'b11111;
    run_flush_ifid = 1'b0;
    run_flush_idex = 1'b0;
    if (ex_branch_taken_i) begin
      run_flush_ifid = 1'b1;
      run_flush_idex = 1'b1;
    end else if (load_use) begin
      run_en         = 5'b00111;
      run_flush_idex = 1'b1;
    end
  end

  always_comb begin
    en           = 5'b00000;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else begin
          en         = run_en;
          flush_ifid = run_flush_ifid;
          flush_idex = run_flush_idex;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_done) begin
          en           = run_en;
          flush_ifid   = run_flush_ifid;
          flush_idex   = run_flush_idex;
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT) begin
          state_nxt = ST_FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Outputs are forced low asynchronously while reset is held.
  assign en_pc_o      = rst_i & en[4];
  assign en_ifid_o    = rst_i & en[3];
  assign en_idex_o    = rst_i & en[2];
  assign en_exmem_o   = rst_i & en[1];
  assign en_memwb_o   = rst_i & en[0];
  assign flush_ifid_o = rst_i & flush_ifid;
  assign flush_idex_o = rst_i & flush_idex;
  assign mem_fault_o  = rst_i & (state == ST_FAULT);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles_o <= '0;
      flush_events_o <= '0;
    end else begin
      if (!en_pc_o && (stall_cycles_o != 32'hFFFF_FFFF)) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end
      if (flush_ifid_o && (flush_events_o != 32'hFFFF_FFFF)) begin
        flush_events_o <= flush_events_o + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
